// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: derives stall/flush
// controls for PC, IF/ID and ID/EX from bus waits, multi-cycle EX ops, jumps and load-use.
module pipe_ctrl #(
   parameter int unsigned MC_TIMEOUT = 64,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_addr_i,
   input  logic [4:0]       id_rs2_addr_i,
   input  logic             id_rs1_used_i,
   input  logic             id_rs2_used_i,
   input  logic [4:0]       ex_rd_addr_i,
   input  logic             ex_mem_re_i,
   input  logic             jump_i,
   input  logic             mc_start_i,
   input  logic             mc_done_i,
   input  logic             ext_stall_i,
   output logic             pc_stall_o,
   output logic             if_id_stall_o,
   output logic             if_id_flush_o,
   output logic             id_ex_stall_o,
   output logic             id_ex_flush_o,
   output logic             mc_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int unsigned TO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(MC_TIMEOUT - 1);
   localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      MC_IDLE = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_e;

   mc_state_e        state_q, state_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, mc_timeout;

   always_comb begin
      load_use = ex_mem_re_i && (ex_rd_addr_i != 5'd0) &&
                 ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                  (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));
   end

   // Single priority chain: the first matching cause owns all controls this cycle.
   always_comb begin
      state_d     = state_q;
      to_cnt_d    = to_cnt_q;
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_stall = 1'b0;
      id_ex_flush = 1'b0;
      mc_timeout  = 1'b0;

      if (ext_stall_i) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_stall = 1'b1;
      end else if (state_q == MC_BUSY) begin
         if (mc_done_i) begin
            state_d = MC_IDLE;
         end else if (to_cnt_q == TO_LAST) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            mc_timeout  = 1'b1;
            state_d     = MC_IDLE;
         end else begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            to_cnt_d    = to_cnt_q + TO_ONE;
         end
      end else if (mc_start_i) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_stall = 1'b1;
         state_d     = MC_BUSY;
         to_cnt_d    = '0;
      end else if (jump_i) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_stall    = 1'b1;
         if_id_stall = 1'b1;
         id_ex_flush = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (pc_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= MC_IDLE;
         to_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Controls are masked while rst is high so the stage registers see no stray hold/bubble.
   assign pc_stall_o    = pc_stall    & ~rst;
   assign if_id_stall_o = if_id_stall & ~rst;
   assign if_id_flush_o = if_id_flush & ~rst;
   assign id_ex_stall_o = id_ex_stall & ~rst;
   assign id_ex_flush_o = id_ex_flush & ~rst;
   assign mc_timeout_o  = mc_timeout  & ~rst;
   assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance for long multi-cycle ops,
// small instance (MC_TIMEOUT=8, CNT_W=4) for timeout and saturation.
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] rs1, rs2, exrd;
   logic       rs1u, rs2u, mre, jmp, mcs, mcd, ext;

   logic        b_pc, b_ifs, b_iff, b_ids, b_idf, b_to;
   logic [31:0] b_cnt;
   logic        s_pc, s_ifs, s_iff, s_ids, s_idf, s_to;
   logic [3:0]  s_cnt;
   logic [5:0]  b_o, s_o;

   // Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, mc_timeout}
   assign b_o = {b_pc, b_ifs, b_iff, b_ids, b_idf, b_to};
   assign s_o = {s_pc, s_ifs, s_iff, s_ids, s_idf, s_to};

   pipe_ctrl #(.MC_TIMEOUT(64), .CNT_W(32)) u_big (
      .clk(clk), .rst(rst),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
      .id_rs1_used_i(rs1u), .id_rs2_used_i(rs2u),
      .ex_rd_addr_i(exrd), .ex_mem_re_i(mre), .jump_i(jmp),
      .mc_start_i(mcs), .mc_done_i(mcd), .ext_stall_i(ext),
      .pc_stall_o(b_pc), .if_id_stall_o(b_ifs), .if_id_flush_o(b_iff),
      .id_ex_stall_o(b_ids), .id_ex_flush_o(b_idf), .mc_timeout_o(b_to),
      .stall_cnt_o(b_cnt)
   );

   pipe_ctrl #(.MC_TIMEOUT(8), .CNT_W(4)) u_small (
      .clk(clk), .rst(rst),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
      .id_rs1_used_i(rs1u), .id_rs2_used_i(rs2u),
      .ex_rd_addr_i(exrd), .ex_mem_re_i(mre), .jump_i(jmp),
      .mc_start_i(mcs), .mc_done_i(mcd), .ext_stall_i(ext),
      .pc_stall_o(s_pc), .if_id_stall_o(s_ifs), .if_id_flush_o(s_iff),
      .id_ex_stall_o(s_ids), .id_ex_flush_o(s_idf), .mc_timeout_o(s_to),
      .stall_cnt_o(s_cnt)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      rs1 = 5'd0; rs2 = 5'd0; exrd = 5'd0;
      rs1u = 1'b0; rs2u = 1'b0; mre = 1'b0;
      jmp = 1'b0; mcs = 1'b0; mcd = 1'b0; ext = 1'b0;
   endtask

   localparam logic [5:0] O_NONE = 6'b000000;
   localparam logic [5:0] O_LU   = 6'b110010;
   localparam logic [5:0] O_JMP  = 6'b001010;
   localparam logic [5:0] O_FRZ  = 6'b110100;
   localparam logic [5:0] O_TO   = 6'b110011;

   initial begin
      idle_in();
      jmp = 1'b1; ext = 1'b1; mcs = 1'b1;
      mre = 1'b1; exrd = 5'd5; rs1 = 5'd5; rs1u = 1'b1;
      #1 rst = 1'b1;
      #6;
      check("rst_big_o", 32'(b_o), 32'(O_NONE));
      check("rst_small_o", 32'(s_o), 32'(O_NONE));
      check("rst_cnt", b_cnt, 32'd0);
      @(negedge clk);
      idle_in();
      rst = 1'b0;
      cyc();

      // load-use detection
      mre = 1'b1; exrd = 5'd5; rs1 = 5'd5; rs1u = 1'b1;
      #1 check("lu_rs1", 32'(b_o), 32'(O_LU));
      cyc();
      check("lu_cnt", b_cnt, 32'd1);
      rs1 = 5'd6;
      #1 check("lu_clear", 32'(b_o), 32'(O_NONE));
      rs1 = 5'd0; exrd = 5'd0;
      #1 check("lu_x0", 32'(b_o), 32'(O_NONE));
      rs1u = 1'b0; rs2u = 1'b1; rs2 = 5'd7; exrd = 5'd7;
      #1 check("lu_rs2", 32'(b_o), 32'(O_LU));
      rs2u = 1'b0;
      #1 check("lu_rs2_unused", 32'(b_o), 32'(O_NONE));
      rs2u = 1'b1; mre = 1'b0;
      #1 check("lu_not_load", 32'(b_o), 32'(O_NONE));
      cyc();

      // jump squashes a simultaneous load-use
      mre = 1'b1; jmp = 1'b1;
      #1 check("jump_lu", 32'(b_o), 32'(O_JMP));
      cyc();
      check("jump_cnt", b_cnt, 32'd1);
      idle_in();

      // 33-cycle divide on the default instance
      mcs = 1'b1;
      #1 check("div_c0", 32'(b_o), 32'(O_FRZ));
      cyc();
      mcs = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         #1 check($sformatf("div_c%0d", c), 32'(b_o), 32'(O_FRZ));
         cyc();
      end
      mcd = 1'b1;
      #1 check("div_done", 32'(b_o), 32'(O_NONE));
      cyc();
      mcd = 1'b0;
      check("div_cnt", b_cnt, 32'd34);
      mcd = 1'b1;
      #1 check("idle_done", 32'(b_o), 32'(O_NONE));
      cyc();
      mcd = 1'b0;
      #1 check("idle_after", 32'(b_o), 32'(O_NONE));
      check("idle_cnt", b_cnt, 32'd34);
      cyc();

      // timeout on the small instance
      mcs = 1'b1;
      #1 check("to_c0", 32'(s_o), 32'(O_FRZ));
      cyc();
      mcs = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         #1 check($sformatf("to_c%0d", c), 32'(s_o), 32'(O_FRZ));
         cyc();
      end
      #1 check("to_pulse", 32'(s_o), 32'(O_TO));
      cyc();
      mcd = 1'b1;
      #1 check("to_idle_s", 32'(s_o), 32'(O_NONE));
      check("to_done_b", 32'(b_o), 32'(O_NONE));
      cyc();
      mcd = 1'b0;
      check("to_cnt_b", b_cnt, 32'd43);

      // ext_stall freezes the timeout counter mid-op
      mcs = 1'b1;
      #1;
      cyc();
      mcs = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         ext = (c >= 4 && c <= 13);
         #1 check($sformatf("frz_c%0d", c), 32'(s_o), 32'(O_FRZ));
         cyc();
      end
      #1 check("frz_pulse", 32'(s_o), 32'(O_TO));
      cyc();

      // async reset while the default instance is still busy
      jmp = 1'b1;
      #1 check("busy_pre", 32'(b_o), 32'(O_FRZ));
      rst = 1'b1;
      #1 check("rst_async_o", 32'(b_o), 32'(O_NONE));
      check("rst_async_cnt", b_cnt, 32'd0);
      check("rst_async_s", 32'(s_o), 32'(O_NONE));
      @(negedge clk);
      rst = 1'b0;
      jmp = 1'b0;
      cyc();
      #1 check("post_rst_idle", 32'(b_o), 32'(O_NONE));
      check("post_rst_cnt", b_cnt, 32'd0);
      cyc();

      // deferred jump under ext_stall
      ext = 1'b1; jmp = 1'b1;
      mre = 1'b1; exrd = 5'd5; rs1 = 5'd5; rs1u = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         #1 check($sformatf("ext_c%0d", c), 32'(b_o), 32'(O_FRZ));
         cyc();
      end
      ext = 1'b0;
      #1 check("ext_jump", 32'(b_o), 32'(O_JMP));
      cyc();
      idle_in();
      check("ext_cnt", b_cnt, 32'd5);

      // saturation of the 4-bit counter
      ext = 1'b1;
      repeat (20) cyc();
      idle_in();
      #1 check("sat_small", 32'(s_cnt), 32'd15);
      check("sat_big", b_cnt, 32'd25);
      ext = 1'b1;
      cyc();
      ext = 1'b0;
      check("sat_hold", 32'(s_cnt), 32'd15);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got stuck expected finish");
      $fatal(1);
   end

endmodule
